// File: rtl/serial_word_assembler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_word_assembler_pkg                                            |
// | Shared types and constants for the serial word assembler.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package serial_word_assembler_pkg;

  localparam int WORD_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Bit counter width; at least one bit so a 1-bit word still has a counter.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_word_assembler_shift_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_collector                                                      |
// | LSB-first word collector with bit counter and parity accumulator.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_collector
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             par_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word,
  output logic             last_bit,
  output logic             parity_ok
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
      par_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      par_q  <= par_d;
    end
  end

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    par_d  = par_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
      par_d  = 1'b0;
    end else if (shift_en) begin
      word_d[cnt_q] = serial_in;
      par_d         = par_q ^ serial_in;
      // Counter parks on the last index so it can never wrap mid-frame.
      if (!last_bit) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (par_en) begin
      par_d = par_q ^ serial_in;
    end
  end

  assign word      = word_q;
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign parity_ok = (par_q == ODD_PARITY);

endmodule
`default_nettype wire

// File: rtl/serial_word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_word_assembler                                                |
// | Frames start/data/parity/stop bits into a word with load strobe.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] dout,
  output logic             load,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             clear, shift_en, par_en;
  logic [WIDTH-1:0] word;
  logic             last_bit, parity_ok;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             load_q, load_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  shift_collector #(
    .WIDTH      (WIDTH),
    .ODD_PARITY (ODD_PARITY)
  ) u_shift_collector (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .shift_en  (shift_en),
    .par_en    (par_en),
    .serial_in (serial_in),
    .word      (word),
    .last_bit  (last_bit),
    .parity_ok (parity_ok)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!serial_in) begin
            clear   = 1'b1;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          if (last_bit) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_en  = 1'b1;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // A bad stop bit masks any parity fault on the same frame.
  always_comb begin
    dout_d       = dout_q;
    load_d       = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    if (bit_valid && (state_q == ST_STOP)) begin
      if (!serial_in) begin
        frame_err_d = 1'b1;
      end else if (!parity_ok) begin
        parity_err_d = 1'b1;
      end else begin
        load_d = 1'b1;
        dout_d = word;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q       <= '0;
      load_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      load_q       <= load_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign load       = load_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
